// File: rtl/line_reverse_xppc.sv
// line_reverse_xppc: emits each video line in reversed pixel order (beats and lanes).
// Two line banks ping-pong: one is written while the other is read backwards.
//
// Handshake: on both AXI4-Stream ports a beat transfers on a rising clk edge where
// tvalid & tready are both 1. A source holds tdata/tuser/tlast stable while
// tvalid=1 and tready=0. tvalid never depends on tready. s_axis_tready depends
// only on registered state.
module line_reverse_xppc #(
  parameter int DATA_WIDTH            = 96,
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int PIXELS_PER_LINE       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic [1:0]            dbg_rd_state
);

  localparam int PPC = MAX_SAMPLES_PER_CLOCK;
  localparam int L   = DATA_WIDTH / PPC;
  localparam int W   = PIXELS_PER_LINE / PPC;
  localparam int AW  = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_READ = 2'd1, RD_DONE = 2'd2} rd_state_e;

  // Write side state. last_q holds the address of the final beat of a bank (len-1).
  logic                   rdy_en_q, rdy_en_d;
  logic                   wr_bank_q, wr_bank_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic                   discard_q, discard_d;
  logic                   overflow_q, overflow_d;
  logic [1:0]             full_q, full_d, sof_q, sof_d;
  logic [1:0][AW-1:0]     last_q, last_d;
  logic [1:0]             close_set, release_clr;
  logic                   wr_fire, wr_en;

  // Read side state
  rd_state_e              rd_state_q, rd_state_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic                   rd_en, rd_bank_sel, start_bank, slot_free;
  logic [AW-1:0]          rd_addr_sel;
  logic [2:0]             occ;
  logic                   pipe_v_q, pipe_v_d, pipe_user_q, pipe_user_d, pipe_last_q, pipe_last_d;

  // Output skid buffer
  logic [1:0][DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]             fifo_user_q, fifo_user_d, fifo_last_q, fifo_last_d;
  logic                   fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;
  logic                   push, pop;
  logic [DATA_WIDTH-1:0]  rev_data;

  // Line storage: banks are the top address bit
  logic [DATA_WIDTH-1:0]  mem [2*W];
  logic [DATA_WIDTH-1:0]  rd_data_q;

  assign s_axis_tready = rdy_en_q & (discard_q | ~full_q[wr_bank_q]);
  assign wr_fire       = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
  assign m_axis_tdata  = fifo_data_q[fifo_rp_q];
  assign m_axis_tuser  = fifo_user_q[fifo_rp_q];
  assign m_axis_tlast  = fifo_last_q[fifo_rp_q];
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign push          = pipe_v_q;
  assign overflow      = overflow_q;
  assign dbg_rd_state  = rd_state_q;
  assign full_d        = (full_q | close_set) & ~release_clr;

  // Write side: store beats, close banks on tlast or when the bank fills, drop overlong tails
  always_comb begin
    rdy_en_d   = 1'b1;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    discard_d  = discard_q;
    overflow_d = overflow_q;
    sof_d      = sof_q;
    last_d     = last_q;
    close_set  = 2'b00;
    wr_en      = 1'b0;
    if (wr_fire) begin
      if (discard_q) begin
        if (s_axis_tlast) discard_d = 1'b0;
      end else begin
        wr_en = 1'b1;
        if (wr_addr_q == '0) sof_d[wr_bank_q] = s_axis_tuser;
        if (s_axis_tlast || (wr_addr_q == AW'(W - 1))) begin
          close_set[wr_bank_q] = 1'b1;
          last_d[wr_bank_q]    = wr_addr_q;
          wr_bank_d            = ~wr_bank_q;
          wr_addr_d            = '0;
          if (!s_axis_tlast) begin
            overflow_d = 1'b1;
            discard_d  = 1'b1;
          end
        end else begin
          wr_addr_d = wr_addr_q + AW'(1);
        end
      end
    end
  end

  // Read side FSM: walk a full bank from its last address down to 0; DONE releases the
  // bank and may start the other bank in the same cycle so lines stream without a gap
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    release_clr = 2'b00;
    rd_en       = 1'b0;
    rd_bank_sel = rd_bank_q;
    rd_addr_sel = rd_addr_q;
    pipe_user_d = 1'b0;
    pipe_last_d = 1'b0;
    start_bank  = (rd_state_q == RD_DONE) ? ~rd_bank_q : rd_bank_q;
    occ         = {2'b00, pipe_v_q} + {1'b0, fifo_cnt_q};
    slot_free   = (occ < (3'd2 + {2'b00, pop}));
    case (rd_state_q)
      RD_READ: begin
        if (slot_free) begin
          rd_en       = 1'b1;
          pipe_last_d = (rd_addr_q == '0);
          if (rd_addr_q == '0) rd_state_d = RD_DONE;
          else                 rd_addr_d  = rd_addr_q - AW'(1);
        end
      end
      default: begin
        if (rd_state_q == RD_DONE) begin
          release_clr[rd_bank_q] = 1'b1;
          rd_bank_d              = ~rd_bank_q;
          rd_state_d             = RD_IDLE;
        end
        if (full_q[start_bank] && slot_free) begin
          rd_en       = 1'b1;
          rd_bank_sel = start_bank;
          rd_addr_sel = last_q[start_bank];
          rd_bank_d   = start_bank;
          pipe_user_d = sof_q[start_bank];
          if (last_q[start_bank] == '0) begin
            pipe_last_d = 1'b1;
            rd_state_d  = RD_DONE;
          end else begin
            rd_addr_d  = last_q[start_bank] - AW'(1);
            rd_state_d = RD_READ;
          end
        end
      end
    endcase
    pipe_v_d = rd_en;
  end

  // Lane reversal of the BRAM word on its way into the skid buffer
  always_comb begin
    rev_data = '0;
    for (int i = 0; i < PPC; i++) rev_data[L*i +: L] = rd_data_q[L*(PPC-1-i) +: L];
  end

  // Skid buffer: two entries, sized by the read-issue credit check above
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_user_d = fifo_user_q;
    fifo_last_d = fifo_last_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_rp_q;
    if (push) begin
      fifo_data_d[fifo_wp_q] = rev_data;
      fifo_user_d[fifo_wp_q] = pipe_user_q;
      fifo_last_d[fifo_wp_q] = pipe_last_q;
      fifo_wp_d              = ~fifo_wp_q;
    end
    if (pop) fifo_rp_d = ~fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q    <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      discard_q   <= 1'b0;
      overflow_q  <= 1'b0;
      full_q      <= 2'b00;
      sof_q       <= 2'b00;
      last_q      <= '0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      pipe_v_q    <= 1'b0;
      pipe_user_q <= 1'b0;
      pipe_last_q <= 1'b0;
      fifo_data_q <= '0;
      fifo_user_q <= 2'b00;
      fifo_last_q <= 2'b00;
      fifo_wp_q   <= 1'b0;
      fifo_rp_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      discard_q   <= discard_d;
      overflow_q  <= overflow_d;
      full_q      <= full_d;
      sof_q       <= sof_d;
      last_q      <= last_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      pipe_v_q    <= pipe_v_d;
      pipe_user_q <= pipe_user_d;
      pipe_last_q <= pipe_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_user_q <= fifo_user_d;
      fifo_last_q <= fifo_last_d;
      fifo_wp_q   <= fifo_wp_d;
      fifo_rp_q   <= fifo_rp_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Line bank RAM: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, wr_addr_q}] <= s_axis_tdata;
    if (rd_en) rd_data_q <= mem[{rd_bank_sel, rd_addr_sel}];
  end

endmodule

// File: tb/tb_line_reverse_xppc.sv
// Bench for line_reverse_xppc: table of line vectors plus hand-written corner sequences.
module tb_line_reverse_xppc;

  localparam int DW  = 96;
  localparam int PPC = 4;
  localparam int L   = DW / PPC;
  localparam int W   = 16;
  localparam int EW  = DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata;
  logic          s_tuser, s_tlast, s_tvalid, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tuser, m_tlast, m_tvalid, m_tready;
  logic          overflow;
  logic [1:0]    dbg_rd_state;

  line_reverse_xppc #(.DATA_WIDTH(DW), .MAX_SAMPLES_PER_CLOCK(PPC), .PIXELS_PER_LINE(64)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .overflow(overflow), .dbg_rd_state(dbg_rd_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int  rdy_mode = 0;   // 0: ready=1, 1: random, 2: ready=0
  bit  count_drops = 0;
  int  drop_cnt = 0;
  int  out_cnt = 0;
  int  user_gap = 0;
  int  prev_fire_cyc = 0;
  bit  prev_stall = 0;
  bit  aborted = 0;
  logic [EW-1:0] prev_out;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [L-1:0] pix(input int id, input int p);
    return {id[15:0], p[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  task automatic wait_accept();
    int t = 0;
    bit acc = 0;
    if (aborted) return;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      checks++;
      failures++;
      aborted = 1;
      $display("FAIL accept_timeout: s_axis_tready stayed 0 for %0d cycles", t);
    end
  endtask

  task automatic drive_beat(input int id, input int b, input bit user, input bit last);
    logic [DW-1:0] d;
    for (int j = 0; j < PPC; j++) d[L*j +: L] = pix(id, PPC*b + j);
    s_tdata  = d;
    s_tuser  = user;
    s_tlast  = last;
    s_tvalid = 1'b1;
    wait_accept();
  endtask

  // Pushes the expected reversed line, then drives its beats (tlast on the final beat)
  task automatic send_line(input int id, input int n, input bit user, input bit rand_v);
    int ns;
    ns = (n > W) ? W : n;
    for (int k = ns - 1; k >= 0; k--) begin
      logic [DW-1:0] d;
      for (int i = 0; i < PPC; i++) d[L*i +: L] = pix(id, PPC*k + PPC - 1 - i);
      exp_q.push_back({user && (k == ns - 1), k == 0, d});
    end
    for (int b = 0; b < n; b++) begin
      if (rand_v) begin
        int g;
        g = $urandom_range(0, 2);
        if (g != 0) begin
          s_tvalid = 1'b0;
          repeat (g) step();
        end
      end
      drive_beat(id, b, user && (b == 0), b == n - 1);
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      step();
      t++;
    end
    repeat (4) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (count_drops && s_tvalid && !s_tready) drop_cnt++;
      if (prev_stall) chk("hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, prev_out});
      if (m_tvalid && m_tready) begin
        out_cnt++;
        if (m_tuser) user_gap = cyc - prev_fire_cyc;
        prev_fire_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat: got %0h expected no beat", {m_tuser, m_tlast, m_tdata});
        end else begin
          chk("beat", {m_tuser, m_tlast, m_tdata}, exp_q.pop_front());
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tuser, m_tlast, m_tdata};
    end
  end

  // ---------------- test sequence ----------------
  typedef struct {
    int nbeats;
    bit user;
    int exp_beats;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    int sum;
    tbl[0] = '{16, 1'b1, 16, 1'b0};  // pixels 0..63
    tbl[1] = '{5,  1'b1, 5,  1'b0};  // short line
    tbl[2] = '{16, 1'b0, 16, 1'b0};  // full line after short
    tbl[3] = '{20, 1'b1, 16, 1'b1};  // overlong: tail dropped
    tbl[4] = '{16, 1'b1, 16, 1'b1};  // next line fine, overflow sticky
    tbl[5] = '{1,  1'b1, 1,  1'b1};  // single-beat line

    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_flags", {m_tuser, m_tlast}, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_s_tready", s_tready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_before", s_tready, 0);
    step();
    chk("rdy_after", s_tready, 1);

    for (int i = 0; i < 6; i++) begin
      out_cnt = 0;
      send_line(i, tbl[i].nbeats, tbl[i].user, 1'b0);
      s_tvalid = 1'b0;
      if (tbl[i].nbeats <= W) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_tvalid && n < 10);
        chk($sformatf("latency%0d", i), (n >= 3 && n <= 4), 1);
        step();
      end
      drain(3000);
      chk($sformatf("count%0d", i), out_cnt, tbl[i].exp_beats);
      chk($sformatf("overflow%0d", i), overflow, tbl[i].exp_ovf);
    end

    // back-to-back lines with tvalid held high
    out_cnt = 0;
    drop_cnt = 0;
    count_drops = 1;
    send_line(10, 16, 1'b1, 1'b0);
    send_line(11, 16, 1'b1, 1'b0);
    count_drops = 0;
    s_tvalid = 1'b0;
    drain(3000);
    chk("b2b_drops", drop_cnt <= 1, 1);
    chk("b2b_gap", user_gap, 1);
    chk("b2b_count", out_cnt, 32);

    // random valid / ready over 100 lines
    rdy_mode = 1;
    out_cnt = 0;
    sum = 0;
    for (int i = 0; i < 100; i++) begin
      int len;
      len = $urandom_range(1, 16);
      sum += len;
      send_line(100 + i, len, 1'($urandom_range(0, 1)), 1'b1);
    end
    s_tvalid = 1'b0;
    drain(20000);
    chk("rand_count", out_cnt, sum);
    rdy_mode = 0;
    repeat (2) step();

    // reset while a line is stalled on the output
    rdy_mode = 2;
    repeat (2) step();
    send_line(300, 16, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    repeat (6) step();
    chk("stall_valid", m_tvalid, 1);
    chk("ovf_before_rst", overflow, 1);
    rst = 1'b1;
    step();
    chk("rst_rd_tvalid", m_tvalid, 0);
    chk("rst_rd_ovf", overflow, 0);
    exp_q.delete();
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) step();
    out_cnt = 0;
    send_line(301, 16, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    drain(3000);
    chk("after_rd_rst_count", out_cnt, 16);

    // reset in the middle of writing a line
    for (int b = 0; b < 5; b++) drive_beat(400, b, b == 0, 1'b0);
    s_tvalid = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_wr_tvalid", m_tvalid, 0);
    chk("rst_wr_ovf", overflow, 0);
    rst = 1'b0;
    repeat (2) step();
    out_cnt = 0;
    send_line(401, 9, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    drain(3000);
    chk("after_wr_rst_count", out_cnt, 9);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_reverse_xppc.md
Name: line_reverse_Xppc

Overview:
- Receives a video line as an AXI4-Stream carrying MAX_SAMPLES_PER_CLOCK pixels per beat.
- Emits the same line in reversed pixel order: beat order is reversed, and lane order within each beat is reversed.
- Sits in the stereo pipeline so the right-to-left disparity path can reuse the left-to-right cost/aggregation blocks. A second instance restores the original order afterwards.
- Uses ping-pong BRAM line buffers so one line is written while the previous one is read.

Parameters:
- DATA_WIDTH, 96: pixel payload bits per beat; must be divisible by MAX_SAMPLES_PER_CLOCK.
- MAX_SAMPLES_PER_CLOCK, 4: pixels per beat (ppc); lane width L = DATA_WIDTH/MAX_SAMPLES_PER_CLOCK.
- PIXELS_PER_LINE, 64: maximum line width in pixels; W = PIXELS_PER_LINE/MAX_SAMPLES_PER_CLOCK beats per bank.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  input pixels, lane 0 = leftmost pixel
- s_axis_tuser  in  1  start of frame; meaningful on the first beat of a line
- s_axis_tlast  in  1  end of line
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  reversed pixels
- m_axis_tuser  out  1  start of frame, on the first output beat of the line
- m_axis_tlast  out  1  last output beat of the line
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- overflow  out  1  sticky: a line exceeded W beats

Behaviour:
- Reset: both banks empty; write and read pointers 0; all outputs 0 except s_axis_tready, which is 1 one cycle after rst deasserts.
- Transfers occur only on tvalid & tready; tdata/tuser/tlast must hold while tvalid=1 and tready=0.
- Storage: two banks of W × (DATA_WIDTH) words (BRAM, read latency 1). Per bank: full flag, length len (1..W), and sof bit.
- Write side:
  - s_axis_tready = 1 while the write bank is not full, or while discarding an overlong line.
  - Each accepted beat is written at wr_addr, then wr_addr increments.
  - sof is latched from tuser of beat 0.
  - A bank closes on an accepted beat with tlast=1, or when wr_addr = W-1 is written. Closing sets full, sets len = wr_addr+1, toggles the write bank and clears wr_addr.
  - Overlong line (bank closed at W with tlast=0): set overflow and enter DISCARD. In DISCARD, accept and drop beats (tready=1) up to and including the tlast beat, then return to WRITE.
- Read side FSM:
  - IDLE: go to READ when the read bank is full.
  - READ: issue reads at addresses len-1 down to 0.
  - DONE: after address 0 is accepted downstream, clear full, toggle the read bank, return to IDLE.
- Output stage: 2-entry skid buffer after the BRAM. A read is issued only if a skid slot is free, counting in-flight reads. Sustains 1 beat/cycle when m_axis_tready=1; no beat is lost or duplicated under any tready pattern.
- Output data: m_axis_tdata lane i (bits L*i +: L) = stored lane MAX_SAMPLES_PER_CLOCK-1-i.
- Output flags: m_axis_tuser = bank sof on the first output beat only. m_axis_tlast = 1 on the beat from address 0.
- Latency: the first output beat of a line is valid no earlier than 2 and no later than 3 cycles after its closing beat is accepted, provided the read side is idle.
- Simultaneous events:
  - Write-close and read-release of different banks in the same cycle are both honoured.
  - If both banks are full, s_axis_tready=0 until a bank is released; the release cycle may accept the next beat.
- rst mid-line discards all stored data. overflow is cleared only by rst.

Test Plan:
- ppc=4, 64 px, single line with pixels 0..63 (beat k = {4k+3,4k+2,4k+1,4k}), m_axis_tready=1 -> 16 output beats carrying 63..0 in lane order; tlast on beat 16; tuser echoed on beat 1 only.
- Back-to-back lines A and B, tvalid=1 continuously -> s_axis_tready never drops for more than 1 cycle per line pair; B output follows A with no gap.
- Short line of 5 beats (tlast on beat 5) -> exactly 5 reversed beats out, tlast on the 5th; next full line unaffected.
- 20-beat line without tlast until beat 20 -> first 16 beats reversed out, beats 17..20 dropped, overflow=1 and sticky; next line correct.
- Random m_axis_tready (50%) and random s_axis_tvalid over 100 lines -> scoreboard matches exact reversed data; no drops or duplicates; tdata stable while stalled.
- rst asserted mid-write and mid-read -> next cycle m_axis_tvalid=0, overflow=0; the first line after reset is output correctly.
